// File: rtl/mem_arb_pkg.sv
// Shared FSM state type, d_rw bit positions and default widths for the memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        I_ACC,
        D_ACC,
        I_DONE,
        D_DONE
    } arb_state_t;

    localparam int RW_RD = 1;
    localparam int RW_WR = 0;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 3;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant selection between fetch and data requesters.
// With ARB_ANTI_STARVE_EN defined, a counter lets fetch win after STARVE_MAX data grants.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
`ifdef ARB_ANTI_STARVE_EN
    input  logic clk,
    input  logic rst,
    input  logic arb,
`endif
    input  logic i_req,
    input  logic d_req,
    output logic grant_i,
    output logic grant_d
);

`ifdef ARB_ANTI_STARVE_EN
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = i_req && (starve_cnt == CNT_W'(STARVE_MAX));
    assign grant_d = d_req && !starved;
    assign grant_i = i_req && !grant_d;

    // Counts data wins only while fetch is waiting; saturates at the limit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (arb) begin
            if (grant_i) begin
                starve_cnt <= '0;
            end else if (grant_d && i_req && (starve_cnt != CNT_W'(STARVE_MAX))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`else
    assign grant_d = d_req;
    assign grant_i = i_req && !d_req;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single memory bus with registered bus fields.
// Optional fetch anti-starvation is enabled by defining ARB_ANTI_STARVE_EN.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [1:0]          d_rw,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                iready_n,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                dready_n,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                dbusy,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    arb_state_t state, state_nxt;
    logic       d_req;
    logic       grant_i;
    logic       grant_d;

    assign d_req = d_rw[RW_RD] | d_rw[RW_WR];

`ifdef ARB_ANTI_STARVE_EN
    logic arb;
    assign arb = (state == IDLE);
`endif

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
`ifdef ARB_ANTI_STARVE_EN
        .clk     (clk),
        .rst     (rst),
        .arb     (arb),
`endif
        .i_req   (i_req),
        .d_req   (d_req),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = D_ACC;
                end else if (grant_i) begin
                    state_nxt = I_ACC;
                end
            end
            I_ACC:   if (mem_ack) state_nxt = I_DONE;
            D_ACC:   if (mem_ack) state_nxt = D_DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready flags are driven from the live request so a withdrawn request never pulses.
    assign iready_n = i_req && (state != I_DONE);
    assign dready_n = d_rw[RW_RD] && (state != D_DONE);
    assign dbusy    = d_rw[RW_WR] && (state != D_DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && (grant_d || grant_i)) begin
                mem_req <= 1'b1;
                if (grant_d) begin
                    // A combined read+write request is serviced as a read only.
                    mem_we    <= d_rw[RW_WR] & ~d_rw[RW_RD];
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                    mem_be    <= d_be;
                end else begin
                    mem_we    <= 1'b0;
                    mem_addr  <= i_addr;
                    mem_wdata <= '0;
                    mem_be    <= '1;
                end
            end
            if ((state == I_ACC) && mem_ack) begin
                mem_req <= 1'b0;
                i_rdata <= mem_rdata;
            end
            if ((state == D_ACC) && mem_ack) begin
                mem_req <= 1'b0;
                d_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: driver pushes expected bus/completion records,
// a negedge monitor pops and compares them; a memory responder acks with modelled data.
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [1:0]    d_rw;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [BW-1:0] d_be;
    logic          iready_n;
    logic [DW-1:0] i_rdata;
    logic          dready_n;
    logic [DW-1:0] d_rdata;
    logic          dbusy;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .d_rw      (d_rw),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .iready_n  (iready_n),
        .i_rdata   (i_rdata),
        .dready_n  (dready_n),
        .d_rdata   (d_rdata),
        .dbusy     (dbusy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        bit            chkw;
    } bus_t;

    typedef struct {
        logic [DW-1:0] data;
        int            lat;
    } cpl_t;

    bus_t exp_bus[$];
    cpl_t exp_f[$];
    cpl_t exp_l[$];
    cpl_t exp_s[$];

    logic [DW-1:0] mem_img [logic [AW-1:0]];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int f_issue  = 0;
    int d_issue  = 0;
    bit f_done   = 1'b0;
    bit d_done   = 1'b0;
    int ack_wait = 0;
    bit resp_en  = 1'b1;
    int inj_cnt  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic void unexpected(input string nm, input logic [63:0] val);
        n_checks++;
        n_err++;
        $display("FAIL %s: event with nothing pending, value 0x%0h expected none", nm, val);
    endfunction

    function automatic void push_bus(input logic [AW-1:0] a, input logic we,
                                     input logic [DW-1:0] wd, input logic [BW-1:0] be, input bit cw);
        exp_bus.push_back('{a, we, wd, be, cw});
    endfunction

    // Memory responder: acks ack_wait cycles after seeing mem_req, or injects a stray ack.
    initial begin : responder
        int wcnt;
        int served;
        wcnt = 0;
        served = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (served != inj_cnt) begin
                mem_ack = 1'b1;
                mem_rdata = 32'hFFFF_FFFF;
                served++;
            end else if (resp_en && mem_req) begin
                if (wcnt >= ack_wait) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd(mem_addr);
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: bus-start, bus-stability and completion checks against the queues.
    initial begin : monitor
        bus_t b;
        bus_t cur;
        cpl_t c;
        logic prev_req;
        prev_req = 1'b0;
        cur = '{'0, 1'b0, '0, '0, 1'b0};
        forever begin
            @(negedge clk);
            f_done = 1'b0;
            d_done = 1'b0;
            if (rst === 1'b1) begin
                if (mem_req && !prev_req) begin
                    if (exp_bus.size() == 0) begin
                        unexpected("bus_start", 64'(mem_addr));
                    end else begin
                        b = exp_bus.pop_front();
                        chk("bus_addr", 64'(mem_addr), 64'(b.addr));
                        chk("bus_we", 64'(mem_we), 64'(b.we));
                        if (b.chkw) begin
                            chk("bus_wdata", 64'(mem_wdata), 64'(b.wdata));
                            chk("bus_be", 64'(mem_be), 64'(b.be));
                        end
                    end
                    cur = '{mem_addr, mem_we, mem_wdata, mem_be, 1'b1};
                end else if (mem_req) begin
                    chk("bus_stable_ctl", 64'({mem_we, mem_be, mem_addr}), 64'({cur.we, cur.be, cur.addr}));
                    chk("bus_stable_wd", 64'(mem_wdata), 64'(cur.wdata));
                end
                if (i_req && !iready_n) begin
                    f_done = 1'b1;
                    if (exp_f.size() == 0) begin
                        unexpected("fetch_done", 64'(i_rdata));
                    end else begin
                        c = exp_f.pop_front();
                        chk("fetch_data", 64'(i_rdata), 64'(c.data));
                        if (c.lat >= 0) chk("fetch_lat", 64'(cyc - f_issue), 64'(c.lat));
                    end
                end
                if (d_rw[1] && !dready_n) begin
                    d_done = 1'b1;
                    if (exp_l.size() == 0) begin
                        unexpected("load_done", 64'(d_rdata));
                    end else begin
                        c = exp_l.pop_front();
                        chk("load_data", 64'(d_rdata), 64'(c.data));
                        if (c.lat >= 0) chk("load_lat", 64'(cyc - d_issue), 64'(c.lat));
                    end
                end else if ((d_rw == 2'b01) && !dbusy) begin
                    d_done = 1'b1;
                    if (exp_s.size() == 0) begin
                        unexpected("store_done", 64'(d_addr));
                    end else begin
                        c = exp_s.pop_front();
                        chk("store_lat", 64'(cyc - d_issue), 64'(c.lat));
                    end
                end
            end
            prev_req = mem_req;
        end
    end

    // Issue a fetch and/or data request from IDLE and hold each until its completion.
    task automatic go(input bit fi, input logic [1:0] rw, input int w);
        @(negedge clk);
        #1;
        ack_wait = w;
        if (rw != 2'b00) begin
            push_bus(d_addr, rw == 2'b01, d_wdata, d_be, rw == 2'b01);
            if (rw[1]) exp_l.push_back('{rd(d_addr), 2 + w});
            else       exp_s.push_back('{'0, 2 + w});
            d_issue = cyc;
            d_rw = rw;
        end
        if (fi) begin
            push_bus(i_addr, 1'b0, '0, '0, 1'b0);
            exp_f.push_back('{rd(i_addr), (rw != 2'b00) ? (2 * (2 + w) + 1) : (2 + w)});
            f_issue = cyc;
            i_req = 1'b1;
        end
        for (int k = 0; k < 60 && (i_req || d_rw != 2'b00); k++) begin
            @(negedge clk);
            #1;
            if (f_done) i_req = 1'b0;
            if (d_done) d_rw = 2'b00;
        end
        chk("drained", 64'({i_req, d_rw}), 64'd0);
        i_req = 1'b0;
        d_rw = 2'b00;
    endtask

    // Fetch held against a stream of back-to-back loads.
    task automatic starve_test();
        logic [AW-1:0] la [4];
        int k;
        k = 0;
        for (int j = 0; j < 4; j++) la[j] = 32'h0000_0500 + 32'(j * 16);
        @(negedge clk);
        #1;
        ack_wait = 0;
`ifdef ARB_ANTI_STARVE_EN
        for (int j = 0; j < 3; j++) push_bus(la[j], 1'b0, '0, '0, 1'b0);
        push_bus(32'h0000_0400, 1'b0, '0, '0, 1'b0);
        push_bus(la[3], 1'b0, '0, '0, 1'b0);
`else
        for (int j = 0; j < 4; j++) push_bus(la[j], 1'b0, '0, '0, 1'b0);
        push_bus(32'h0000_0400, 1'b0, '0, '0, 1'b0);
`endif
        for (int j = 0; j < 4; j++) exp_l.push_back('{rd(la[j]), -1});
        exp_f.push_back('{rd(32'h0000_0400), -1});
        i_addr = 32'h0000_0400;
        i_req = 1'b1;
        d_addr = la[0];
        d_rw = 2'b10;
        for (int c = 0; c < 80 && (i_req || d_rw != 2'b00); c++) begin
            @(negedge clk);
            #1;
            if (f_done) i_req = 1'b0;
            if (d_done) begin
                k++;
                if (k < 4) d_addr = la[k];
                else       d_rw = 2'b00;
            end
        end
        chk("starve_drained", 64'({i_req, d_rw}), 64'd0);
        i_req = 1'b0;
        d_rw = 2'b00;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        bit         fi;
        logic [1:0] rw;
        int         w;
        rst = 1'b0;
        i_req = 1'b0;
        i_addr = '0;
        d_rw = 2'b00;
        d_addr = '0;
        d_wdata = '0;
        d_be = '0;
        mem_img[32'h0000_0100] = 32'hDEAD_BEEF;

        repeat (3) @(negedge clk);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_mem_be", 64'(mem_be), 64'd0);
        chk("rst_i_rdata", 64'(i_rdata), 64'd0);
        chk("rst_d_rdata", 64'(d_rdata), 64'd0);
        chk("rst_flags", 64'({iready_n, dready_n, dbusy}), 64'd0);
        #1;
        rst = 1'b1;

        i_addr = 32'h0000_0100;
        go(1'b1, 2'b00, 0);

        i_addr = 32'h0000_0180;
        d_addr = 32'h0000_0200;
        go(1'b1, 2'b10, 0);

        d_addr = 32'h0000_0240;
        d_wdata = 32'h1234_5678;
        d_be = 4'hF;
        go(1'b0, 2'b01, 2);

        d_addr = 32'h0000_0280;
        d_wdata = 32'hCAFE_F00D;
        d_be = 4'h3;
        go(1'b0, 2'b11, 1);

        starve_test();

        // Reset while a load is on the bus, then a stray ack afterwards.
        resp_en = 1'b0;
        @(negedge clk);
        #1;
        d_addr = 32'h0000_0300;
        push_bus(32'h0000_0300, 1'b0, '0, '0, 1'b0);
        d_rw = 2'b10;
        @(negedge clk);
        #1;
        chk("pre_rst_mem_req", 64'(mem_req), 64'd1);
        rst = 1'b0;
        d_rw = 2'b00;
        @(negedge clk);
        chk("rst_mid_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mid_d_rdata", 64'(d_rdata), 64'd0);
        chk("rst_mid_mem_addr", 64'(mem_addr), 64'd0);
        #1;
        rst = 1'b1;
        inj_cnt++;
        repeat (4) @(negedge clk);
        chk("stray_ack_d_rdata", 64'(d_rdata), 64'd0);
        chk("stray_ack_i_rdata", 64'(i_rdata), 64'd0);
        chk("stray_ack_mem_req", 64'(mem_req), 64'd0);
        #1;
        resp_en = 1'b1;

        // Fetch withdrawn mid-access still completes on the bus.
        @(negedge clk);
        #1;
        ack_wait = 2;
        i_addr = 32'h0000_0440;
        push_bus(32'h0000_0440, 1'b0, '0, '0, 1'b0);
        i_req = 1'b1;
        @(negedge clk);
        #1;
        i_req = 1'b0;
        repeat (6) @(negedge clk);
        chk("withdraw_i_rdata", 64'(i_rdata), 64'(rd(32'h0000_0440)));
        chk("withdraw_mem_req", 64'(mem_req), 64'd0);

        for (int n = 0; n < 24; n++) begin
            w = $urandom_range(0, 3);
            rw = 2'($urandom_range(0, 3));
            fi = (rw == 2'b00) ? 1'b1 : 1'($urandom_range(0, 1));
            i_addr = $urandom() & 32'hFFFF_FFFC;
            d_addr = $urandom() & 32'hFFFF_FFFC;
            d_wdata = $urandom();
            d_be = 4'($urandom_range(1, 15));
            go(fi, rw, w);
        end

        repeat (3) @(negedge clk);
        chk("bus_queue_left", 64'(exp_bus.size()), 64'd0);
        chk("fetch_queue_left", 64'(exp_f.size()), 64'd0);
        chk("load_queue_left", 64'(exp_l.size()), 64'd0);
        chk("store_queue_left", 64'(exp_s.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
